// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, fixed-latency memory between fetch and load/store.
// Optional build macro ARB_RR_EN swaps fixed data priority for round-robin on ties.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT  = 2,
  parameter int unsigned MAX_DGNT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        flush,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

  state_t           state, state_nxt;
  owner_t           owner;
  logic             cancel;
  logic             we_q;
  logic [LAT_W-1:0] lat_cnt;
  logic             if_elig;
  logic             grant_any;
  logic             grant_fetch;

`ifdef ARB_RR_EN
  owner_t last_owner;
`else
  localparam int unsigned ST_W = $clog2(MAX_DGNT + 1);
  localparam logic [ST_W-1:0] ST_MAX = ST_W'(MAX_DGNT);
  logic [ST_W-1:0] starve_cnt;
`endif

  // Fetch is never eligible in a cycle where a jump is being taken.
  assign if_elig   = if_req & ~flush;
  assign grant_any = if_elig | d_req;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    grant_fetch = 1'b0;
    if (if_elig && !d_req) begin
      grant_fetch = 1'b1;
    end else if (if_elig && d_req) begin
`ifdef ARB_RR_EN
      grant_fetch = (last_owner == OWN_DATA);
`else
      grant_fetch = (starve_cnt == ST_MAX);
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = (MEM_LAT == 1) ? RESP : WAIT;
      WAIT:    if (lat_cnt == LAT_LAST) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: only control and datapath flops are reset here; there is no storage array to clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner     <= OWN_FETCH;
      cancel    <= 1'b0;
      we_q      <= 1'b0;
      lat_cnt   <= '0;
      if_gnt    <= 1'b0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_valid   <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_gnt   <= 1'b0;
      d_gnt    <= 1'b0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            cancel <= 1'b0;
            mem_en <= 1'b1;
            if (grant_fetch) begin
              owner    <= OWN_FETCH;
              if_gnt   <= 1'b1;
              mem_addr <= if_addr;
              we_q     <= 1'b0;
            end else begin
              owner     <= OWN_DATA;
              d_gnt     <= 1'b1;
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
              we_q      <= d_we;
            end
          end
        end
        ISSUE: lat_cnt <= LAT_W'(1);
        WAIT:  lat_cnt <= lat_cnt + LAT_W'(1);
        RESP: begin
          if (owner == OWN_DATA) begin
            d_valid <= 1'b1;
            d_rdata <= we_q ? 32'h0 : mem_rdata;
          end else if (!(cancel || flush)) begin
            if_valid <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
      // A cancelled fetch still runs to completion on the memory side.
      if (state != IDLE && owner == OWN_FETCH && flush) cancel <= 1'b1;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_owner <= OWN_FETCH;
    end else if (state == IDLE && grant_any) begin
      last_owner <= grant_fetch ? OWN_FETCH : OWN_DATA;
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (state == IDLE && grant_any) begin
      if (grant_fetch || !if_req)  starve_cnt <= '0;
      else if (starve_cnt != ST_MAX) starve_cnt <= starve_cnt + ST_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 instance with full stimulus and
// a MEM_LAT=1 instance exercised by fetch only.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Main instance (MEM_LAT = 2)
  logic        if_req = 1'b0, flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic        if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

  // Second instance (MEM_LAT = 1), fetch side only
  logic        if_req1 = 1'b0;
  logic [31:0] if_addr1 = '0;
  logic        zero_bit = 1'b0;
  logic [31:0] zero_word = '0;
  logic        if_gnt1, if_valid1, d_gnt1, d_valid1, mem_en1, mem_we1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

  mem_port_arbiter #(.MEM_LAT(2), .MAX_DGNT(4)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.MEM_LAT(1), .MAX_DGNT(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req1), .if_addr(if_addr1), .flush(zero_bit),
    .if_gnt(if_gnt1), .if_valid(if_valid1), .if_rdata(if_rdata1),
    .d_req(zero_bit), .d_we(zero_bit), .d_addr(zero_word), .d_wdata(zero_word),
    .d_gnt(d_gnt1), .d_valid(d_valid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  // Memory contents as a pure function of address; writes are checked at the port.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h80) ? 32'h0050_0093 : {a[15:0], 16'hC0DE};
  endfunction

  // Latency-2 memory: data for a cycle-N strobe is visible during cycle N+2.
  logic [1:0]  pv0 = '0;
  logic [31:0] pd0_0 = '0, pd0_1 = '0;
  always @(posedge clk) begin
    pv0   <= {pv0[0], mem_en};
    pd0_0 <= mem_word(mem_addr);
    pd0_1 <= pd0_0;
  end
  assign mem_rdata = pv0[1] ? pd0_1 : 32'hBAD0_BAD0;

  // Latency-1 memory: data for a cycle-N strobe is visible during cycle N+1.
  logic        pv1 = 1'b0;
  logic [31:0] pd1 = '0;
  always @(posedge clk) begin
    pv1 <= mem_en1;
    pd1 <= mem_word(mem_addr1);
  end
  assign mem_rdata1 = pv1 ? pd1 : 32'hBAD0_BAD0;

  logic [133:0] all_out;
  assign all_out = {if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
                    mem_en, mem_we, mem_addr, mem_wdata};

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    step(2);
    checks++;
    if (all_out !== 134'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    checks++;
    if ({if_gnt1, if_valid1, mem_en1} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outputs_lat1 got=%b exp=000", {if_gnt1, if_valid1, mem_en1});
    end
    reset_n = 1'b1;
    step(2);
  endtask

  task automatic test_fetch_read();
    if_req = 1'b1; if_addr = 32'h80;
    step();                                        // cycle N
    checks++;
    if ({mem_en, if_gnt, d_gnt, mem_we, mem_addr} !== {4'b1100, 32'h80}) begin
      failures++;
      $display("FAIL fetch_issue got=%b_%h exp=1100_00000080",
               {mem_en, if_gnt, d_gnt, mem_we}, mem_addr);
    end
    if_req = 1'b0;
    step();                                        // N+1
    checks++;
    if ({mem_en, if_gnt, if_valid} !== 3'b000) begin
      failures++;
      $display("FAIL fetch_single_strobe got=%b exp=000", {mem_en, if_gnt, if_valid});
    end
    step(2);                                       // N+3
    checks++;
    if ({if_valid, d_valid, if_rdata} !== {2'b10, 32'h0050_0093}) begin
      failures++;
      $display("FAIL fetch_return got=%b_%h exp=10_00500093", {if_valid, d_valid}, if_rdata);
    end
    step();
  endtask

  task automatic test_data_write_read();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    step();                                        // N
    checks++;
    if ({mem_en, mem_we, d_gnt, if_gnt, mem_addr, mem_wdata} !==
        {4'b1110, 32'h200, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL write_issue got=%b_%h_%h exp=1110_00000200_deadbeef",
               {mem_en, mem_we, d_gnt, if_gnt}, mem_addr, mem_wdata);
    end
    d_req = 1'b0; d_we = 1'b0;
    step(3);                                       // N+3
    checks++;
    if ({d_valid, if_valid, d_rdata} !== {2'b10, 32'h0}) begin
      failures++;
      $display("FAIL write_complete got=%b_%h exp=10_00000000", {d_valid, if_valid}, d_rdata);
    end
    step();
    d_req = 1'b1; d_addr = 32'h300;
    step();                                        // N
    checks++;
    if ({mem_en, mem_we, d_gnt} !== 3'b101) begin
      failures++;
      $display("FAIL read_issue got=%b exp=101", {mem_en, mem_we, d_gnt});
    end
    d_req = 1'b0;
    step(3);
    checks++;
    if ({d_valid, d_rdata} !== {1'b1, 32'h0300_C0DE}) begin
      failures++;
      $display("FAIL data_read_return got=%b_%h exp=1_0300c0de", d_valid, d_rdata);
    end
    step();
  endtask

  task automatic test_flush();
    logic saw_gnt;
    // A flushing cycle blocks fetch eligibility in IDLE.
    if_req = 1'b1; if_addr = 32'hC0; flush = 1'b1;
    saw_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      saw_gnt |= if_gnt | mem_en;
    end
    checks++;
    if (saw_gnt !== 1'b0) begin
      failures++;
      $display("FAIL flush_blocks_idle got=%b exp=0", saw_gnt);
    end
    flush = 1'b0;
    step();                                        // N
    checks++;
    if ({if_gnt, mem_en} !== 2'b11) begin
      failures++;
      $display("FAIL flushed_fetch_issue got=%b exp=11", {if_gnt, mem_en});
    end
    if_req = 1'b0; flush = 1'b1;                   // flush during N+1
    step();
    flush = 1'b0;
    step(2);                                       // N+3
    checks++;
    if ({if_valid, if_rdata} !== {1'b0, 32'h0050_0093}) begin
      failures++;
      $display("FAIL flush_suppress got=%b_%h exp=0_00500093", if_valid, if_rdata);
    end
    step();
    if_req = 1'b1; if_addr = 32'h100;
    step();
    if_req = 1'b0;
    step(3);
    checks++;
    if ({if_valid, if_rdata} !== {1'b1, 32'h0100_C0DE}) begin
      failures++;
      $display("FAIL fetch_after_flush got=%b_%h exp=1_0100c0de", if_valid, if_rdata);
    end
    step();
  endtask

  task automatic test_contention();
    logic [5:0] got;
    logic [5:0] exp;
    int n, dual_gnt, dual_valid;
`ifdef ARB_RR_EN
    exp = 6'b101010;                               // D,F,D,F,D,F
`else
    exp = 6'b111101;                               // D,D,D,D,F,D
`endif
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    got = '0; n = 0; dual_gnt = 0; dual_valid = 0;
    if_req = 1'b1; if_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
    for (int c = 0; c < 40 && n < 6; c++) begin
      step();
      if (if_gnt && d_gnt) dual_gnt++;
      if (if_valid && d_valid) dual_valid++;
      if (d_gnt || if_gnt) begin
        got = {got[4:0], d_gnt};
        n++;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    checks++;
    if (n !== 6) begin
      failures++;
      $display("FAIL contention_grant_count got=%0d exp=6", n);
    end
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL contention_order got=%b exp=%b (1=data)", got, exp);
    end
    checks++;
    if (dual_gnt + dual_valid !== 0) begin
      failures++;
      $display("FAIL contention_exclusive got=%0d exp=0", dual_gnt + dual_valid);
    end
    step(5);
  endtask

  task automatic test_reset_midop();
    logic saw_valid;
    if_req = 1'b1; if_addr = 32'h180;
    step();                                        // N
    checks++;
    if (if_gnt !== 1'b1) begin
      failures++;
      $display("FAIL midop_grant got=%b exp=1", if_gnt);
    end
    if_req = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (all_out !== 134'd0) begin
      failures++;
      $display("FAIL midop_async_clear got=%h exp=0", all_out);
    end
    step();
    reset_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      saw_valid |= if_valid | d_valid;
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      failures++;
      $display("FAIL midop_no_valid got=%b exp=0", saw_valid);
    end
    if_req = 1'b1; if_addr = 32'h1C0;
    step();
    checks++;
    if ({if_gnt, mem_en, mem_addr} !== {2'b11, 32'h1C0}) begin
      failures++;
      $display("FAIL post_reset_issue got=%b_%h exp=11_000001c0", {if_gnt, mem_en}, mem_addr);
    end
    if_req = 1'b0;
    step(3);
    checks++;
    if ({if_valid, if_rdata} !== {1'b1, 32'h01C0_C0DE}) begin
      failures++;
      $display("FAIL post_reset_return got=%b_%h exp=1_01c0c0de", if_valid, if_rdata);
    end
    step();
  endtask

  task automatic test_lat1_back_to_back();
    if_req1 = 1'b1; if_addr1 = 32'h40;
    step();                                        // N
    checks++;
    if ({mem_en1, if_gnt1, mem_addr1} !== {2'b11, 32'h40}) begin
      failures++;
      $display("FAIL lat1_issue0 got=%b_%h exp=11_00000040", {mem_en1, if_gnt1}, mem_addr1);
    end
    if_addr1 = 32'h44;                             // request held for the next read
    step();                                        // N+1
    checks++;
    if ({mem_en1, if_valid1} !== 2'b00) begin
      failures++;
      $display("FAIL lat1_gap1 got=%b exp=00", {mem_en1, if_valid1});
    end
    step();                                        // N+2
    checks++;
    if ({mem_en1, if_valid1, if_rdata1} !== {2'b01, 32'h0040_C0DE}) begin
      failures++;
      $display("FAIL lat1_return0 got=%b_%h exp=01_0040c0de", {mem_en1, if_valid1}, if_rdata1);
    end
    step();                                        // N+3
    checks++;
    if ({mem_en1, if_gnt1, mem_addr1} !== {2'b11, 32'h44}) begin
      failures++;
      $display("FAIL lat1_issue1 got=%b_%h exp=11_00000044", {mem_en1, if_gnt1}, mem_addr1);
    end
    if_req1 = 1'b0;
    step(2);                                       // N+5
    checks++;
    if ({if_valid1, if_rdata1} !== {1'b1, 32'h0044_C0DE}) begin
      failures++;
      $display("FAIL lat1_return1 got=%b_%h exp=1_0044c0de", if_valid1, if_rdata1);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_data_write_read();
    test_flush();
    test_contention();
    test_reset_midop();
    test_lat1_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
